seq_chunk_adder: RTL and testbench

Multi-cycle sequencer that adds two unsigned operands of 3·NCHUNK bits by driving a single 3-bit ripple-carry adder slice once per cycle, least-significant chunk first, with a registered carry between chunks. It sits between an upstream operand producer and a downstream result consumer. Both sides use valid/ready handshakes. This lets the team reuse the small 3-bit adder datapath for wide additions instead of instantiating a wide adder.

---
 rtl/seq_chunk_adder_if.sv | 28 ++
 rtl/seq_chunk_adder.sv | 103 ++++++++++
 tb/tb_seq_chunk_adder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder.
// The master side is the producer and consumer; the slave side is the adder.
interface seq_chunk_adder_if #(
  parameter int NCHUNK = 4
);
  localparam int W = 3 * NCHUNK;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Wide unsigned adder built from one 3-bit ripple slice.
// The slice is reused once per cycle, lowest chunk first, with a registered carry.
module seq_chunk_adder #(
  parameter int NCHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int W  = 3 * NCHUNK;
  localparam int IW = $clog2(NCHUNK);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic [IW-1:0] idx_reg;
  logic          cout_reg;

  logic [2:0]    a_chunk [NCHUNK];
  logic [2:0]    b_chunk [NCHUNK];
  logic [2:0]    sum_chunk_reg [NCHUNK];
  logic [W-1:0]  sum_flat;
  logic [2:0]    a_sel;
  logic [2:0]    b_sel;
  logic [3:0]    slice_res;
  logic          accept;
  logic          last_chunk;

  assign accept     = (state_reg == IDLE) && bus.in_valid;
  assign last_chunk = (idx_reg == IW'(NCHUNK - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi]        = a_reg[3*gi +: 3];
      assign b_chunk[gi]        = b_reg[3*gi +: 3];
      assign sum_flat[3*gi +: 3] = sum_chunk_reg[gi];

      // Each result chunk is written only on the cycle its index is active.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_chunk_reg[gi] <= '0;
        end else if (accept) begin
          sum_chunk_reg[gi] <= '0;
        end else if (state_reg == RUN && idx_reg == IW'(gi)) begin
          sum_chunk_reg[gi] <= slice_res[2:0];
        end
      end
    end
  endgenerate

  assign a_sel     = a_chunk[idx_reg];
  assign b_sel     = b_chunk[idx_reg];
  assign slice_res = {1'b0, a_sel} + {1'b0, b_sel} + {3'b000, carry_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          carry_reg <= slice_res[3];
          if (last_chunk) begin
            cout_reg  <= slice_res[3];
            state_reg <= HOLD;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.sum       = sum_flat;
  assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder with a cycle-level transaction model.
// Model: accept -> NCHUNK busy cycles -> hold until released; result = a+b+cin.
module tb_seq_chunk_adder;
  localparam int NCHUNK = 4;
  localparam int W      = 3 * NCHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.NCHUNK(NCHUNK)) ifc ();

  seq_chunk_adder #(.NCHUNK(NCHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural model: 0 = waiting for operands, 1 = computing, 2 = result offered
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [W:0]   m_q[$];
  logic [W:0]   m_last  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_q.delete();
      m_last  = '0;
    end else begin
      cyc++;
      case (m_phase)
        0: if (ifc.in_valid) begin
             m_q.push_back({1'b0, ifc.a} + {1'b0, ifc.b} + {{W{1'b0}}, ifc.cin});
             m_cnt   = NCHUNK;
             m_phase = 1;
           end
        1: begin
             m_cnt--;
             if (m_cnt == 0) m_phase = 2;
           end
        default: if (ifc.out_ready) begin
             m_last  = m_q.pop_front();
             m_phase = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  64'(ifc.in_ready),  64'(m_phase == 0));
    chk("out_valid", 64'(ifc.out_valid), 64'(m_phase == 2));
    chk("busy",      64'(ifc.busy),      64'(m_phase != 0));
    if (m_phase == 2 && m_q.size() > 0)
      chk("hold_result", 64'({ifc.cout, ifc.sum}), 64'(m_q[0]));
    else if (m_phase == 0)
      chk("idle_result", 64'({ifc.cout, ifc.sum}), 64'(m_last));
  end

  // Release monitor for throughput/order checks
  logic [W:0] rel_q[$];
  int         rel_t[$];
  always @(posedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      rel_q.push_back({ifc.cout, ifc.sum});
      rel_t.push_back(cyc);
    end
  end

  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic [W-1:0] es, input logic ec, input int hold);
    int n;
    int lat;
    ifc.out_ready = (hold == 0);
    n = 0;
    while (!ifc.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_ready_wait"}, 64'(n < 100), 64'd1);
    ifc.a = ta; ifc.b = tb_; ifc.cin = tc; ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(NCHUNK));
    for (int i = 0; i < hold; i++) begin
      ifc.in_valid = (i % 2 == 0);
      ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.cin = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_bp_valid"}, 64'(ifc.out_valid), 64'd1);
      chk({tag, "_bp_sum"},   64'(ifc.sum),       64'(es));
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    chk({tag, "_sum"},  64'(ifc.sum),  64'(es));
    chk({tag, "_cout"}, 64'(ifc.cout), 64'(ec));
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    chk({tag, "_ready_after_release"}, 64'(ifc.in_ready), 64'd1);
    $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d latency=%0d", tag, ta, tb_, tc,
             ifc.sum, ifc.cout, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic         pc [3];
    logic [W:0]   pexp [3];
    int           n;

    ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0; ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum",  64'(ifc.sum),  64'd0);
    chk("reset_cout", 64'(ifc.cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("6+1",       12'h006, 12'h001, 1'b0, 12'h007, 1'b0, 0);
    do_op("7+1",       12'h007, 12'h001, 1'b0, 12'h008, 1'b0, 0);
    do_op("fff+1",     12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 0);
    do_op("fff+0+cin", 12'hFFF, 12'h000, 1'b1, 12'h000, 1'b1, 0);
    do_op("bp_5+4",    12'h005, 12'h004, 1'b0, 12'h009, 1'b0, 6);

    // Reset in the middle of a computation
    ifc.a = 12'h555; ifc.b = 12'h2AA; ifc.cin = 1'b0; ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  64'(ifc.in_ready),  64'd1);
    chk("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("midrst_busy",      64'(ifc.busy),      64'd0);
    chk("midrst_sum",       64'(ifc.sum),       64'd0);
    chk("midrst_cout",      64'(ifc.cout),      64'd0);
    $display("op midrst: reset asserted after 2 busy cycles");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("2+3", 12'h002, 12'h003, 1'b0, 12'h005, 1'b0, 0);

    // Back-to-back with in_valid held high and out_ready held high
    pa[0] = 12'h123; pb[0] = 12'h456; pc[0] = 1'b0; pexp[0] = 13'h0579;
    pa[1] = 12'h800; pb[1] = 12'h800; pc[1] = 1'b1; pexp[1] = 13'h1001;
    pa[2] = 12'hABC; pb[2] = 12'h111; pc[2] = 1'b0; pexp[2] = 13'h0BCD;
    rel_q.delete(); rel_t.delete();
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ifc.a = pa[k]; ifc.b = pb[k]; ifc.cin = pc[k]; ifc.in_valid = 1'b1;
      n = 0;
      while (!ifc.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("b2b_accept_wait", 64'(n < 100), 64'd1);
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    n = 0;
    while (rel_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b_release_count", 64'(rel_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < rel_q.size(); k++) begin
      chk("b2b_result", 64'(rel_q[k]), 64'(pexp[k]));
      if (k > 0) chk("b2b_interval", 64'(rel_t[k] - rel_t[k-1]), 64'(NCHUNK + 2));
      $display("op b2b%0d: a=%h b=%h cin=%0d -> {cout,sum}=%h", k, pa[k], pb[k], pc[k], rel_q[k]);
    end
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
